// File: rtl/bus_responder_mem_if.sv
// Five-channel ready/valid bus between an initiator (master) and a responder (slave).
// Latency: none, signal bundle only.
// Backpressure: each channel carries its own valid/ready pair; transfer on valid && ready.
interface bus_responder_mem_if;
    logic [7:0] bus_addr_write_bus_data;
    logic       bus_addr_write_bus_valid;
    logic       bus_addr_write_bus_ready;
    logic [7:0] bus_data_write_bus_data;
    logic       bus_data_write_bus_valid;
    logic       bus_data_write_bus_ready;
    logic [7:0] bus_resp_write_bus_data;
    logic       bus_resp_write_bus_valid;
    logic       bus_resp_write_bus_ready;
    logic [7:0] bus_addr_read_bus_data;
    logic       bus_addr_read_bus_valid;
    logic       bus_addr_read_bus_ready;
    logic [7:0] bus_data_read_bus_data;
    logic       bus_data_read_bus_valid;
    logic       bus_data_read_bus_ready;

    modport master (
        output bus_addr_write_bus_data, bus_addr_write_bus_valid,
        input  bus_addr_write_bus_ready,
        output bus_data_write_bus_data, bus_data_write_bus_valid,
        input  bus_data_write_bus_ready,
        input  bus_resp_write_bus_data, bus_resp_write_bus_valid,
        output bus_resp_write_bus_ready,
        output bus_addr_read_bus_data, bus_addr_read_bus_valid,
        input  bus_addr_read_bus_ready,
        input  bus_data_read_bus_data, bus_data_read_bus_valid,
        output bus_data_read_bus_ready
    );

    modport slave (
        input  bus_addr_write_bus_data, bus_addr_write_bus_valid,
        output bus_addr_write_bus_ready,
        input  bus_data_write_bus_data, bus_data_write_bus_valid,
        output bus_data_write_bus_ready,
        output bus_resp_write_bus_data, bus_resp_write_bus_valid,
        input  bus_resp_write_bus_ready,
        input  bus_addr_read_bus_data, bus_addr_read_bus_valid,
        output bus_addr_read_bus_ready,
        output bus_data_read_bus_data, bus_data_read_bus_valid,
        input  bus_data_read_bus_ready
    );
endinterface

// File: rtl/bus_responder_mem.sv
// Memory-backed bus responder: DEPTH x 8-bit storage behind a 5-channel ready/valid bus.
// Latency: write commits the cycle after both holding registers fill, response visible next cycle; read data 1 cycle after address.
// Backpressure: a stalled write response keeps both write holding registers full (write readies low); read address ready = !rd_valid || read-data ready.
// Optional feature macro BUS_RESPONDER_RANGE_CHECK_EN: out-of-range writes answer 8'h02 without updating memory, out-of-range reads return ERR_DATA.
// Without it DEPTH must be a power of two and addresses wrap on their low log2(DEPTH) bits.
module bus_responder_mem #(
    parameter int unsigned DEPTH    = 256,
    parameter logic [7:0]  ERR_DATA = 8'hFF
) (
    input  logic               clk,
    input  logic               rst,
    bus_responder_mem_if.slave bus
);
    localparam int unsigned AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0]  RESP_OKAY  = 8'h00;
    localparam logic [7:0]  RESP_ERROR = 8'h02;

    logic [7:0]    mem_q [0:DEPTH-1];

    logic [7:0]    aw_q, aw_d;
    logic          aw_full_q, aw_full_d;
    logic [7:0]    w_q, w_d;
    logic          w_full_q, w_full_d;
    logic          resp_vld_q, resp_vld_d;
    logic [7:0]    resp_dat_q, resp_dat_d;
    logic          rd_vld_q, rd_vld_d;
    logic [7:0]    rd_dat_q, rd_dat_d;

    logic          aw_hs, w_hs, resp_hs, ar_hs, rd_hs, commit;
    logic [AW-1:0] wr_idx, rd_idx;
    logic          wr_in_range;
    logic [7:0]    rd_word;
    logic          unused_ok;

    // Readies come from registered state only; the read address side may also look at read-data ready.
    assign bus.bus_addr_write_bus_ready = !aw_full_q;
    assign bus.bus_data_write_bus_ready = !w_full_q;
    assign bus.bus_addr_read_bus_ready  = !rd_vld_q || bus.bus_data_read_bus_ready;
    assign bus.bus_resp_write_bus_valid = resp_vld_q;
    assign bus.bus_resp_write_bus_data  = resp_dat_q;
    assign bus.bus_data_read_bus_valid  = rd_vld_q;
    assign bus.bus_data_read_bus_data   = rd_dat_q;

    assign aw_hs   = bus.bus_addr_write_bus_valid && !aw_full_q;
    assign w_hs    = bus.bus_data_write_bus_valid && !w_full_q;
    assign resp_hs = resp_vld_q && bus.bus_resp_write_bus_ready;
    assign ar_hs   = bus.bus_addr_read_bus_valid && bus.bus_addr_read_bus_ready;
    assign rd_hs   = rd_vld_q && bus.bus_data_read_bus_ready;
    // A write commits only when the response slot is free or being drained this cycle.
    assign commit  = aw_full_q && w_full_q && (!resp_vld_q || bus.bus_resp_write_bus_ready);

    assign wr_idx = (DEPTH > 1) ? aw_q[AW-1:0] : '0;
    assign rd_idx = (DEPTH > 1) ? bus.bus_addr_read_bus_data[AW-1:0] : '0;

`ifdef BUS_RESPONDER_RANGE_CHECK_EN
    assign wr_in_range = ({1'b0, aw_q} < 9'(DEPTH));
    assign rd_word     = ({1'b0, bus.bus_addr_read_bus_data} < 9'(DEPTH)) ? mem_q[rd_idx] : ERR_DATA;
`else
    assign wr_in_range = 1'b1;
    assign rd_word     = mem_q[rd_idx];
`endif

    // Address bits above the index are deliberately ignored in the wrapping build.
    assign unused_ok = ^{aw_q, bus.bus_addr_read_bus_data, ERR_DATA};

    // Next state for write holding registers, write response and read output register.
    always_comb begin
        aw_d       = aw_q;
        aw_full_d  = aw_full_q;
        w_d        = w_q;
        w_full_d   = w_full_q;
        resp_vld_d = resp_vld_q;
        resp_dat_d = resp_dat_q;
        rd_vld_d   = rd_vld_q;
        rd_dat_d   = rd_dat_q;

        if (aw_hs) begin
            aw_d      = bus.bus_addr_write_bus_data;
            aw_full_d = 1'b1;
        end
        if (w_hs) begin
            w_d      = bus.bus_data_write_bus_data;
            w_full_d = 1'b1;
        end

        if (commit) begin
            aw_full_d  = 1'b0;
            w_full_d   = 1'b0;
            resp_vld_d = 1'b1;
            resp_dat_d = wr_in_range ? RESP_OKAY : RESP_ERROR;
        end else if (resp_hs) begin
            resp_vld_d = 1'b0;
        end

        if (ar_hs) begin
            rd_dat_d = rd_word;
            rd_vld_d = 1'b1;
        end else if (rd_hs) begin
            rd_vld_d = 1'b0;
        end
    end

    // Control and output registers; reset drops any captured or pending transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_q       <= '0;
            aw_full_q  <= 1'b0;
            w_q        <= '0;
            w_full_q   <= 1'b0;
            resp_vld_q <= 1'b0;
            resp_dat_q <= '0;
            rd_vld_q   <= 1'b0;
            rd_dat_q   <= '0;
        end else begin
            aw_q       <= aw_d;
            aw_full_q  <= aw_full_d;
            w_q        <= w_d;
            w_full_q   <= w_full_d;
            resp_vld_q <= resp_vld_d;
            resp_dat_q <= resp_dat_d;
            rd_vld_q   <= rd_vld_d;
            rd_dat_q   <= rd_dat_d;
        end
    end

    // Storage is not reset; a read on the commit edge sees the pre-write value.
    always_ff @(posedge clk) begin
        if (commit && wr_in_range) begin
            mem_q[wr_idx] <= w_q;
        end
    end
endmodule

// File: tb/tb_bus_responder_mem.sv
// Self-checking bench for bus_responder_mem with a DEPTH=128 instance.
// Directed scenarios plus randomized traffic compared against an array model.
// Model follows the range-check macro when it is defined.
module tb_bus_responder_mem;
    localparam int DEPTH = 128;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    bus_responder_mem_if bif();

    bus_responder_mem #(.DEPTH(DEPTH), .ERR_DATA(8'hFF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    // Bench-side drivers and views of the interface.
    logic [7:0] aw_dat, w_dat, ar_dat;
    logic       aw_vld, w_vld, ar_vld, resp_rdy, rd_rdy;
    wire        aw_rdy   = bif.bus_addr_write_bus_ready;
    wire        w_rdy    = bif.bus_data_write_bus_ready;
    wire        ar_rdy   = bif.bus_addr_read_bus_ready;
    wire        resp_vld = bif.bus_resp_write_bus_valid;
    wire  [7:0] resp_dat = bif.bus_resp_write_bus_data;
    wire        rd_vld   = bif.bus_data_read_bus_valid;
    wire  [7:0] rd_dat   = bif.bus_data_read_bus_data;
    assign bif.bus_addr_write_bus_data  = aw_dat;
    assign bif.bus_addr_write_bus_valid = aw_vld;
    assign bif.bus_data_write_bus_data  = w_dat;
    assign bif.bus_data_write_bus_valid = w_vld;
    assign bif.bus_resp_write_bus_ready = resp_rdy;
    assign bif.bus_addr_read_bus_data   = ar_dat;
    assign bif.bus_addr_read_bus_valid  = ar_vld;
    assign bif.bus_data_read_bus_ready  = rd_rdy;

    // Reference model: plain array indexed by effective address.
    logic [7:0] mdl [0:255];
    logic [7:0] resp_seen [$];

    function automatic bit mdl_in_range(input logic [7:0] a);
`ifdef BUS_RESPONDER_RANGE_CHECK_EN
        return int'(a) < DEPTH;
`else
        return 1'b1;
`endif
    endfunction

    function automatic int mdl_slot(input logic [7:0] a);
        return int'(a) % DEPTH;
    endfunction

    function automatic logic [7:0] exp_resp(input logic [7:0] a);
        return mdl_in_range(a) ? 8'h00 : 8'h02;
    endfunction

    function automatic logic [7:0] exp_read(input logic [7:0] a);
        return mdl_in_range(a) ? mdl[mdl_slot(a)] : 8'hFF;
    endfunction

    task automatic mdl_write(input logic [7:0] a, input logic [7:0] d);
        if (mdl_in_range(a)) mdl[mdl_slot(a)] = d;
    endtask

    // Present address and data together until both are accepted.
    task automatic drive_write(input logic [7:0] a, input logic [7:0] d, output bit ok);
        bit a_done, d_done, a_hs, d_hs;
        a_done = 0; d_done = 0;
        aw_dat = a; w_dat = d; aw_vld = 1; w_vld = 1;
        for (int n = 0; n < 40 && !(a_done && d_done); n++) begin
            a_hs = aw_vld && aw_rdy;
            d_hs = w_vld && w_rdy;
            @(posedge clk); #1;
            if (a_hs) begin aw_vld = 0; a_done = 1; end
            if (d_hs) begin w_vld = 0; d_done = 1; end
        end
        aw_vld = 0; w_vld = 0;
        ok = a_done && d_done;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d, input bit stall,
                             output logic [7:0] resp, output bit ok);
        bit wok, got;
        drive_write(a, d, wok);
        got = 0; resp = 8'hEE;
        for (int n = 0; n < 60 && !got; n++) begin
            resp_rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (resp_vld && resp_rdy) begin resp = resp_dat; got = 1; end
            @(posedge clk); #1;
        end
        resp_rdy = 0;
        ok = wok && got;
    endtask

    task automatic bus_read(input logic [7:0] a, input bit stall, output logic [7:0] d, output bit ok);
        bit accepted, got, a_hs, r_hs;
        accepted = 0; got = 0; d = 8'hEE;
        ar_dat = a; ar_vld = 1;
        for (int n = 0; n < 60 && !got; n++) begin
            rd_rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            a_hs = ar_vld && ar_rdy;
            r_hs = accepted && rd_vld && rd_rdy;
            if (r_hs) d = rd_dat;
            @(posedge clk); #1;
            if (a_hs) begin ar_vld = 0; accepted = 1; end
            if (r_hs) got = 1;
        end
        ar_vld = 0; rd_rdy = 0;
        ok = got;
    endtask

    task automatic collect_resp(input int cycles);
        for (int n = 0; n < cycles; n++) begin
            if (resp_vld && resp_rdy) resp_seen.push_back(resp_dat);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1;
        aw_dat = 0; w_dat = 0; ar_dat = 0;
        aw_vld = 0; w_vld = 0; ar_vld = 0; resp_rdy = 0; rd_rdy = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (aw_rdy !== 1'b1)   begin failures++; $display("FAIL reset_aw_rdy got=%b exp=1", aw_rdy); end
        checks++; if (w_rdy !== 1'b1)    begin failures++; $display("FAIL reset_w_rdy got=%b exp=1", w_rdy); end
        checks++; if (ar_rdy !== 1'b1)   begin failures++; $display("FAIL reset_ar_rdy got=%b exp=1", ar_rdy); end
        checks++; if (resp_vld !== 1'b0) begin failures++; $display("FAIL reset_resp_vld got=%b exp=0", resp_vld); end
        checks++; if (resp_dat !== 8'h00) begin failures++; $display("FAIL reset_resp_dat got=%h exp=00", resp_dat); end
        checks++; if (rd_vld !== 1'b0)   begin failures++; $display("FAIL reset_rd_vld got=%b exp=0", rd_vld); end
        checks++; if (rd_dat !== 8'h00)  begin failures++; $display("FAIL reset_rd_dat got=%h exp=00", rd_dat); end
        rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_first_write();
        aw_dat = 8'h10; w_dat = 8'hA5; aw_vld = 1; w_vld = 1; resp_rdy = 1;
        @(posedge clk); #1;
        aw_vld = 0; w_vld = 0;
        checks++; if (resp_vld !== 1'b0) begin failures++; $display("FAIL fw_resp_early got=%b exp=0", resp_vld); end
        checks++; if (aw_rdy !== 1'b0)   begin failures++; $display("FAIL fw_aw_held got=%b exp=0", aw_rdy); end
        @(posedge clk); #1;
        checks++; if (resp_vld !== 1'b1) begin failures++; $display("FAIL fw_resp_vld got=%b exp=1", resp_vld); end
        checks++; if (resp_dat !== 8'h00) begin failures++; $display("FAIL fw_resp_dat got=%h exp=00", resp_dat); end
        checks++; if (aw_rdy !== 1'b1)   begin failures++; $display("FAIL fw_aw_free got=%b exp=1", aw_rdy); end
        @(posedge clk); #1;
        checks++; if (resp_vld !== 1'b0) begin failures++; $display("FAIL fw_resp_drained got=%b exp=0", resp_vld); end
        resp_rdy = 0;
        mdl_write(8'h10, 8'hA5);
        ar_dat = 8'h10; ar_vld = 1; rd_rdy = 1;
        #1;
        checks++; if (ar_rdy !== 1'b1) begin failures++; $display("FAIL fw_ar_rdy got=%b exp=1", ar_rdy); end
        @(posedge clk); #1;
        ar_vld = 0;
        checks++; if (rd_vld !== 1'b1) begin failures++; $display("FAIL fw_rd_vld got=%b exp=1", rd_vld); end
        checks++; if (rd_dat !== exp_read(8'h10)) begin failures++; $display("FAIL fw_rd_dat got=%h exp=%h", rd_dat, exp_read(8'h10)); end
        @(posedge clk); #1;
        checks++; if (rd_vld !== 1'b0) begin failures++; $display("FAIL fw_rd_drained got=%b exp=0", rd_vld); end
        rd_rdy = 0;
    endtask

    task automatic test_data_before_addr();
        logic [7:0] d;
        bit ok;
        w_dat = 8'h3C; w_vld = 1; resp_rdy = 1;
        @(posedge clk); #1;
        w_vld = 0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (w_rdy !== 1'b0)    begin failures++; $display("FAIL dba_w_hold[%0d] got=%b exp=0", i, w_rdy); end
            checks++; if (resp_vld !== 1'b0) begin failures++; $display("FAIL dba_no_resp[%0d] got=%b exp=0", i, resp_vld); end
            @(posedge clk); #1;
        end
        aw_dat = 8'h20; aw_vld = 1;
        @(posedge clk); #1;
        aw_vld = 0;
        resp_seen.delete();
        collect_resp(6);
        resp_rdy = 0;
        checks++; if (resp_seen.size() !== 1) begin failures++; $display("FAIL dba_resp_count got=%0d exp=1", resp_seen.size()); end
        if (resp_seen.size() > 0) begin
            checks++; if (resp_seen[0] !== exp_resp(8'h20)) begin failures++; $display("FAIL dba_resp_code got=%h exp=%h", resp_seen[0], exp_resp(8'h20)); end
        end
        mdl_write(8'h20, 8'h3C);
        bus_read(8'h20, 0, d, ok);
        checks++; if (!ok || d !== exp_read(8'h20)) begin failures++; $display("FAIL dba_read ok=%0d got=%h exp=%h", ok, d, exp_read(8'h20)); end
    endtask

    task automatic test_resp_backpressure();
        bit ok1, ok2, ok;
        logic [7:0] d;
        resp_rdy = 0;
        drive_write(8'h22, 8'h5A, ok1);
        drive_write(8'h21, 8'h77, ok2);
        checks++; if (!(ok1 && ok2)) begin failures++; $display("FAIL bp_capture got=%0d%0d exp=11", ok1, ok2); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (aw_rdy !== 1'b0 || w_rdy !== 1'b0) begin failures++; $display("FAIL bp_readies[%0d] got=%b%b exp=00", i, aw_rdy, w_rdy); end
            checks++; if (resp_vld !== 1'b1) begin failures++; $display("FAIL bp_resp_hold[%0d] got=%b exp=1", i, resp_vld); end
            @(posedge clk); #1;
        end
        resp_seen.delete();
        resp_rdy = 1;
        collect_resp(8);
        resp_rdy = 0;
        checks++; if (resp_seen.size() !== 2) begin failures++; $display("FAIL bp_resp_count got=%0d exp=2", resp_seen.size()); end
        for (int i = 0; i < resp_seen.size(); i++) begin
            checks++; if (resp_seen[i] !== 8'h00) begin failures++; $display("FAIL bp_resp_code[%0d] got=%h exp=00", i, resp_seen[i]); end
        end
        mdl_write(8'h22, 8'h5A);
        mdl_write(8'h21, 8'h77);
        bus_read(8'h21, 0, d, ok);
        checks++; if (!ok || d !== exp_read(8'h21)) begin failures++; $display("FAIL bp_read21 ok=%0d got=%h exp=%h", ok, d, exp_read(8'h21)); end
        bus_read(8'h22, 0, d, ok);
        checks++; if (!ok || d !== exp_read(8'h22)) begin failures++; $display("FAIL bp_read22 ok=%0d got=%h exp=%h", ok, d, exp_read(8'h22)); end
    endtask

    task automatic test_back_to_back_reads();
        logic [7:0] addrs [3];
        addrs[0] = 8'h10; addrs[1] = 8'h20; addrs[2] = 8'h10;
        rd_rdy = 1; ar_vld = 1;
        for (int i = 0; i < 3; i++) begin
            ar_dat = addrs[i];
            #1;
            checks++; if (ar_rdy !== 1'b1) begin failures++; $display("FAIL b2b_ar_rdy[%0d] got=%b exp=1", i, ar_rdy); end
            @(posedge clk); #1;
            checks++; if (rd_vld !== 1'b1 || rd_dat !== exp_read(addrs[i])) begin
                failures++; $display("FAIL b2b_data[%0d] vld=%b got=%h exp=%h", i, rd_vld, rd_dat, exp_read(addrs[i]));
            end
        end
        ar_vld = 0;
        @(posedge clk); #1;
        checks++; if (rd_vld !== 1'b0) begin failures++; $display("FAIL b2b_drained got=%b exp=0", rd_vld); end

        rd_rdy = 0; ar_dat = 8'h10; ar_vld = 1;
        #1;
        checks++; if (ar_rdy !== 1'b1) begin failures++; $display("FAIL stall_first_ar_rdy got=%b exp=1", ar_rdy); end
        @(posedge clk); #1;
        ar_dat = 8'h20;
        for (int i = 0; i < 3; i++) begin
            checks++; if (ar_rdy !== 1'b0) begin failures++; $display("FAIL stall_ar_rdy[%0d] got=%b exp=0", i, ar_rdy); end
            checks++; if (rd_vld !== 1'b1 || rd_dat !== exp_read(8'h10)) begin
                failures++; $display("FAIL stall_hold[%0d] vld=%b got=%h exp=%h", i, rd_vld, rd_dat, exp_read(8'h10));
            end
            @(posedge clk); #1;
        end
        rd_rdy = 1;
        #1;
        checks++; if (ar_rdy !== 1'b1) begin failures++; $display("FAIL stall_release_ar_rdy got=%b exp=1", ar_rdy); end
        @(posedge clk); #1;
        ar_vld = 0;
        checks++; if (rd_vld !== 1'b1 || rd_dat !== exp_read(8'h20)) begin
            failures++; $display("FAIL stall_next vld=%b got=%h exp=%h", rd_vld, rd_dat, exp_read(8'h20));
        end
        @(posedge clk); #1;
        rd_rdy = 0;
    endtask

    task automatic test_same_cycle_rw();
        logic [7:0] r, d, old_val;
        bit ok;
        bus_write(8'h30, 8'h11, 0, r, ok);
        checks++; if (!ok || r !== exp_resp(8'h30)) begin failures++; $display("FAIL rw_prewrite ok=%0d got=%h exp=%h", ok, r, exp_resp(8'h30)); end
        mdl_write(8'h30, 8'h11);
        old_val = exp_read(8'h30);
        aw_dat = 8'h30; w_dat = 8'h22; aw_vld = 1; w_vld = 1; resp_rdy = 1;
        @(posedge clk); #1;
        aw_vld = 0; w_vld = 0;
        ar_dat = 8'h30; ar_vld = 1; rd_rdy = 1;
        @(posedge clk); #1;
        ar_vld = 0;
        checks++; if (resp_vld !== 1'b1) begin failures++; $display("FAIL rw_commit got=%b exp=1", resp_vld); end
        checks++; if (rd_vld !== 1'b1 || rd_dat !== old_val) begin failures++; $display("FAIL rw_old vld=%b got=%h exp=%h", rd_vld, rd_dat, old_val); end
        mdl_write(8'h30, 8'h22);
        @(posedge clk); #1;
        resp_rdy = 0; rd_rdy = 0;
        bus_read(8'h30, 0, d, ok);
        checks++; if (!ok || d !== exp_read(8'h30)) begin failures++; $display("FAIL rw_new ok=%0d got=%h exp=%h", ok, d, exp_read(8'h30)); end
    endtask

    task automatic test_range();
        logic [7:0] r, d;
        bit ok;
        bus_write(8'h90, 8'hC3, 0, r, ok);
        checks++; if (!ok || r !== exp_resp(8'h90)) begin failures++; $display("FAIL range_resp ok=%0d got=%h exp=%h", ok, r, exp_resp(8'h90)); end
        mdl_write(8'h90, 8'hC3);
        bus_read(8'h90, 0, d, ok);
        checks++; if (!ok || d !== exp_read(8'h90)) begin failures++; $display("FAIL range_read90 ok=%0d got=%h exp=%h", ok, d, exp_read(8'h90)); end
        bus_read(8'h10, 0, d, ok);
        checks++; if (!ok || d !== exp_read(8'h10)) begin failures++; $display("FAIL range_read10 ok=%0d got=%h exp=%h", ok, d, exp_read(8'h10)); end
    endtask

    task automatic test_random();
        logic [7:0] written [$];
        logic [7:0] a, d, r;
        bit ok;
        for (int i = 0; i < 60; i++) begin
            if (written.size() == 0 || $urandom_range(0, 1) == 1) begin
                a = 8'($urandom); d = 8'($urandom);
                bus_write(a, d, 1, r, ok);
                checks++; if (!ok || r !== exp_resp(a)) begin failures++; $display("FAIL rnd_write[%0d] a=%h ok=%0d got=%h exp=%h", i, a, ok, r, exp_resp(a)); end
                mdl_write(a, d);
                written.push_back(a);
            end else begin
                a = written[$urandom_range(0, written.size() - 1)];
                bus_read(a, 1, d, ok);
                checks++; if (!ok || d !== exp_read(a)) begin failures++; $display("FAIL rnd_read[%0d] a=%h ok=%0d got=%h exp=%h", i, a, ok, d, exp_read(a)); end
            end
        end
    endtask

    task automatic test_async_reset();
        resp_rdy = 0; rd_rdy = 0;
        aw_dat = 8'h40; aw_vld = 1; ar_dat = 8'h10; ar_vld = 1;
        @(posedge clk); #1;
        aw_vld = 0; ar_vld = 0;
        checks++; if (aw_rdy !== 1'b0 || rd_vld !== 1'b1) begin failures++; $display("FAIL ar_pre aw_rdy=%b rd_vld=%b exp=0/1", aw_rdy, rd_vld); end
        #2;
        rst = 1;
        #1;
        checks++; if (rd_vld !== 1'b0 || resp_vld !== 1'b0) begin failures++; $display("FAIL ar_valids rd=%b resp=%b exp=0/0", rd_vld, resp_vld); end
        checks++; if (aw_rdy !== 1'b1 || rd_dat !== 8'h00) begin failures++; $display("FAIL ar_state aw_rdy=%b rd_dat=%h exp=1/00", aw_rdy, rd_dat); end
        @(posedge clk); #1;
        rst = 0;
        w_dat = 8'h99; w_vld = 1; resp_rdy = 1;
        @(posedge clk); #1;
        w_vld = 0;
        resp_seen.delete();
        collect_resp(5);
        resp_rdy = 0;
        checks++; if (resp_seen.size() !== 0) begin failures++; $display("FAIL ar_no_resp got=%0d exp=0", resp_seen.size()); end
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        checks++; if (w_rdy !== 1'b1) begin failures++; $display("FAIL ar_w_cleared got=%b exp=1", w_rdy); end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_write();
        test_data_before_addr();
        test_resp_backpressure();
        test_back_to_back_reads();
        test_same_cycle_rw();
        test_range();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bus_responder_mem.md
Name: bus_responder_mem

Overview:
- Memory-backed responder: the target end of the 5-channel composite ready/valid bus.
  - Accepts write-address, write-data and read-address requests from an initiator.
  - Returns read data and write responses.
- Backs a DEPTH x 8-bit register array.
- Sits below any bus passthrough/adapter as the terminal endpoint for bus-level tests and small on-chip storage.

Parameters:
- DEPTH, 256, number of 8-bit words; 1..256.
- ERR_DATA, 8'hFF, read data returned for out-of-range addresses (range-check build only).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- bus_addr_write_bus_data  in  8  write address.
- bus_addr_write_bus_valid  in  1  write address valid.
- bus_addr_write_bus_ready  out  1  write address ready.
- bus_data_write_bus_data  in  8  write data.
- bus_data_write_bus_valid  in  1  write data valid.
- bus_data_write_bus_ready  out  1  write data ready.
- bus_resp_write_bus_data  out  8  write response code.
- bus_resp_write_bus_valid  out  1  write response valid.
- bus_resp_write_bus_ready  in  1  write response ready.
- bus_addr_read_bus_data  in  8  read address.
- bus_addr_read_bus_valid  in  1  read address valid.
- bus_addr_read_bus_ready  out  1  read address ready.
- bus_data_read_bus_data  out  8  read data.
- bus_data_read_bus_valid  out  1  read data valid.
- bus_data_read_bus_ready  in  1  read data ready.

Behaviour:
- Handshake rule: a transfer occurs on a clk edge where valid && ready.
  - Outputs with valid=1 hold data stable until accepted.
  - No output ready depends combinationally on the same channel's valid.
- Reset (rst high, async):
  - aw_full=0, w_full=0.
  - resp_valid=0, resp_data=0.
  - rd_valid=0, rd_data=0.
  - Resulting readies: addr_write_ready=1, data_write_ready=1, addr_read_ready=1.
  - Memory contents are not reset.
  - Any captured or pending transaction is dropped silently.
- Write path:
  - Address holding register aw_reg/aw_full; bus_addr_write_bus_ready = !aw_full.
  - Data holding register w_reg/w_full; bus_data_write_bus_ready = !w_full.
  - The two channels are independent: address may arrive before, after or with data.
  - Commit condition: aw_full && w_full && (!resp_valid || resp_ready).
  - On commit:
    - mem[aw_reg] <= w_reg if in range.
    - aw_full <= 0, w_full <= 0.
    - resp_valid <= 1, resp_data <= status.
  - On resp handshake without commit: resp_valid <= 0.
  - Latency: commit occurs the cycle after both holding registers are full; the response is visible the next cycle.
  - Throughput: max one write per 2 cycles.
- Response codes: 8'h00 OKAY, 8'h02 ERROR.
- Read path (1-deep output register):
  - bus_addr_read_bus_ready = !rd_valid || bus_data_read_bus_ready.
  - On addr_read handshake: rd_data <= mem[addr], rd_valid <= 1.
  - Else on data_read handshake: rd_valid <= 0.
  - Latency 1 cycle; full throughput (1 read/cycle) under constant data_read ready.
- Simultaneous read and write commit to the same address:
  - Read returns the old (pre-write) value.
  - The write still commits.
- Backpressure: while resp_valid=1 and resp_ready=0, commit stalls. Holding registers stay full, so the address and data write readies stay 0.

Optional Feature:
- Macro: BUS_RESPONDER_RANGE_CHECK_EN.
- Defined:
  - Address >= DEPTH on write: no memory update, resp 8'h02.
  - Address >= DEPTH on read: data ERR_DATA.
  - In-range accesses behave normally, resp 8'h00.
- Undefined:
  - DEPTH must be a power of two.
  - Addresses use the low log2(DEPTH) bits (wrap).
  - Response is always 8'h00; ERR_DATA unused.

Test Plan:
- Reset, then write addr 0x10 and data 0xA5 in the same cycle, resp_ready=1:
  - resp_valid=1 with 0x00 exactly 2 cycles after the handshake.
  - Then read 0x10 returns 0xA5 one cycle after the addr handshake.
- Data 0x3C presented 3 cycles before addr 0x20:
  - data_write_ready=0 while holding.
  - Single resp 0x00.
  - Read 0x20 returns 0x3C.
- resp_ready held 0 for 5 cycles after the first write:
  - Second write (0x21/0x77) is captured but not committed.
  - Both readies stay 0.
  - After resp_ready=1: two responses in order; 0x21 reads 0x77.
- Back-to-back reads of 0x10, 0x20, 0x10 with data_read_ready=1:
  - rd_valid=1 for 3 consecutive cycles returning 0xA5, 0x3C, 0xA5.
  - Then repeat with data_read_ready=0: addr_read_ready drops to 0 and rd_data holds.
- Read and write to 0x30 (old 0x11, new 0x22) in the same cycle the commit fires:
  - Read returns 0x11; a subsequent read returns 0x22.
- With the macro defined and DEPTH=128:
  - Write 0x90 gives resp 0x02, no memory change.
  - Read 0x90 returns 0xFF.
- Without the macro: write 0x90 updates mem[0x10]. Assert rst mid-capture: all valids 0 asynchronously and no response issued.
